fp8_mult_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined 8-bit floating-point multiplier (1 sign, 3 exponent bias 3, 4 mantissa, implicit leading 1) among N_REQ requesters, such as systolic processing elements or a host loader. It accepts at most one operand pair per cycle through a valid/ready handshake and drives the multiplier inputs. It tracks each issued operation's requester ID through the multiplier latency and returns every product tagged with that ID.

---
 rtl/fp8_mult_arbiter.sv | 121 ++++++++++++
 tb/tb_fp8_mult_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_mult_arbiter.sv
// rtl/fp8_mult_arbiter.sv - round-robin arbiter sharing one pipelined fp8 multiplier, optional FP8_ARB_FIXED_PRIO_EN
module fp8_mult_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 3,
    parameter int IDW      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 hold,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [7:0]           mul_out,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [7:0]           res_data,
    output logic                 busy
);

    logic [N_REQ-1:0]             grant;
    logic [IDW-1:0]               gid;
    logic [IDW-1:0]               idx;
    logic                         fire;
    logic [7:0]                   sel_a;
    logic [7:0]                   sel_b;
    logic [MULT_LAT:0]            tag_v;
    logic [MULT_LAT:0][IDW-1:0]   tag_id;

`ifndef FP8_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]               ptr;
`endif

    // Grant search: first valid requester at or after ptr (or lowest index in fixed mode).
    // Reset is folded in so req_ready reads zero the moment rst_n drops.
    always_comb begin
        grant = '0;
        gid   = '0;
        idx   = '0;
        fire  = 1'b0;
        if (rst_n && !hold) begin
            for (int k = 0; k < N_REQ; k++) begin
`ifdef FP8_ARB_FIXED_PRIO_EN
                idx = IDW'(k);
`else
                idx = IDW'((int'(ptr) + k) % N_REQ);
`endif
                if (!fire && req_valid[idx]) begin
                    fire       = 1'b1;
                    gid        = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_a = req_a[8*k +: 8];
                sel_b = req_b[8*k +: 8];
            end
        end
    end

`ifndef FP8_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past the last granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + 1'b1;
        end
    end
`endif

    // Multiplier operand registers hold their value between transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (fire) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
        end
    end

    // Tag pipeline: stage MULT_LAT lines up with mul_out for the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[MULT_LAT-1:0], fire};
            tag_id <= {tag_id[MULT_LAT-1:0], (fire ? gid : IDW'(0))};
        end
    end

    // Result register captures the product one edge after its tag reaches the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_v[MULT_LAT];
            res_id    <= tag_id[MULT_LAT];
            res_data  <= mul_out;
        end
    end

    assign busy = |tag_v;

endmodule

// File: tb/tb_fp8_mult_arbiter.sv
// tb/tb_fp8_mult_arbiter.sv - randomized scoreboard bench for fp8_mult_arbiter
module tb_fp8_mult_arbiter;

    localparam int N   = 4;
    localparam int ML  = 3;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_a = '0;
    logic [8*N-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic             hold = 1'b0;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [7:0]       mul_out;
    logic             res_valid;
    logic [IDW-1:0]   res_id;
    logic [7:0]       res_data;
    logic             busy;

    fp8_mult_arbiter #(.N_REQ(N), .MULT_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .hold(hold), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // fp8 product: 1 sign, 3 exponent (bias 3), 4 mantissa; exponent 0 flushes to zero
    function automatic logic [7:0] fp8mul(input logic [7:0] a, input logic [7:0] b);
        logic s;
        int ea, eb, e, p;
        logic [3:0] m;
        s  = a[7] ^ b[7];
        ea = int'(a[6:4]);
        eb = int'(b[6:4]);
        if (ea == 0 || eb == 0) return {s, 7'h00};
        p = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        e = ea + eb - 3;
        if (p >= 512) begin
            m = 4'((p >> 5) & 15);
            e = e + 1;
        end else begin
            m = 4'((p >> 4) & 15);
        end
        if (e <= 0) return {s, 7'h00};
        if (e > 7)  return {s, 7'h7F};
        return {s, 3'(e), m};
    endfunction

    // Behavioural multiplier with ML edges of latency
    logic [7:0] mpipe [ML];
    always @(posedge clk) begin
        mpipe[0] <= fp8mul(mul_a, mul_b);
        for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_out = mpipe[ML-1];

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } ent_t;

    ent_t       q[$];
    int         n = 0;
    int         ptr_m = 0;
    logic [7:0] ma_m = '0;
    logic [7:0] mb_m = '0;
    int         last_g = -1;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int exp_grant();
        int idx;
        if (hold) return -1;
        for (int k = 0; k < N; k++) begin
`ifdef FP8_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (ptr_m + k) % N;
`endif
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model on the rising edge
    task automatic cycle();
        int         g;
        logic [N-1:0] eg;
        logic       ev, eb;
        int         eid;
        logic [7:0] ed;
        @(negedge clk);
        g  = exp_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(eg));
        check("mul_a", 32'(mul_a), 32'(ma_m));
        check("mul_b", 32'(mul_b), 32'(mb_m));
        ev = 1'b0; eb = 1'b0; eid = 0; ed = '0;
        foreach (q[i]) begin
            if (q[i].due == n) begin
                ev = 1'b1; eid = q[i].id; ed = q[i].data;
            end
            if (n < q[i].due) eb = 1'b1;
        end
        check("res_valid", 32'(res_valid), 32'(ev));
        if (ev) begin
            check("res_id", 32'(res_id), 32'(eid));
            check("res_data", 32'(res_data), 32'(ed));
        end
        check("busy", 32'(busy), 32'(eb));
        @(posedge clk);
        n++;
        while (q.size() > 0 && q[0].due < n) void'(q.pop_front());
        if (g >= 0) begin
            ma_m = req_a[8*g +: 8];
            mb_m = req_b[8*g +: 8];
            q.push_back('{due: n + ML + 1, id: g, data: fp8mul(ma_m, mb_m)});
            ptr_m = (g + 1) % N;
        end
        last_g = g;
        #1;
    endtask

    task automatic new_pair(input int i);
        req_a[8*i +: 8] = 8'($urandom);
        req_b[8*i +: 8] = 8'($urandom);
    endtask

    // Random requesters obeying the hold-stable-until-granted rule
    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || last_g == i) begin
                req_valid[i] = ($urandom_range(0, 99) < 60);
                new_pair(i);
            end else if ($urandom_range(0, 99) < 5) begin
                req_valid[i] = 1'b0;
            end
        end
        hold = ($urandom_range(0, 99) < 15);
    endtask

    // Called 1 time unit after a rising edge; asserts reset mid-cycle
    task automatic do_reset();
        req_valid = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) new_pair(i);
        hold = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        q.delete();
        ptr_m = 0;
        ma_m = '0;
        mb_m = '0;
        @(posedge clk);
        n++;
        #1;
        rst_n = 1'b1;
        last_g = -1;
    endtask

    task automatic drain(input int cycles);
        req_valid = '0;
        hold = 1'b0;
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    initial begin
        do_reset();

        // Single request: 1.5 * 1.0
        req_valid = 4'b0001;
        req_a[7:0] = 8'h38;
        req_b[7:0] = 8'h30;
        cycle();
        drain(ML + 4);

        // All requesters continuously valid
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) new_pair(i);
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (last_g >= 0) new_pair(last_g);
        end
        drain(ML + 4);

        // Two issues, then hold with everyone valid
        req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            cycle();
            if (last_g >= 0) new_pair(last_g);
        end
        hold = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        drain(ML + 4);

        // Three issues, reset kills them, next grant starts from requester 0
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (last_g >= 0) new_pair(last_g);
        end
        do_reset();
        req_valid = 4'b0101;
        hold = 1'b0;
        cycle();
        drain(ML + 6);

        // Requesters 1 and 3 valid, then 1 drops
        req_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (last_g >= 0) new_pair(last_g);
        end
        req_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (last_g >= 0) new_pair(last_g);
        end
        drain(ML + 4);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rand_inputs();
                cycle();
            end
        end
        drain(ML + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
